mem_io_bridge: RTL and testbench

//  Parametrised successor to the Mem2IO/tristate pair between the SLC-3 CPU core and the external async SRAM.
//  The CPU issues req/ack transactions (MAR/MDR side); the block runs an FSM that drives SRAM strobes with configurable wait states and byte enables.
//  It decodes a memory-mapped I/O window: switches are readable, and NUM_DISP display registers are writable and feed the hex drivers.
//  All SRAM strobes are active-low.

---
 rtl/mem_io_bridge.sv | 178 +++++++++++++++++
 tb/tb_mem_io_bridge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : mem_io_bridge
//  Brief    : CPU req/ack to asynchronous SRAM bridge with wait states, byte
//             enables and a small memory-mapped I/O window (switches + display
//             registers).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_io_bridge #(
    parameter int                CPU_AW      = 16,
    parameter int                SRAM_AW     = 20,
    parameter int                DATA_W      = 16,
    parameter int                WAIT_CYCLES = 2,
    parameter int                NUM_DISP    = 2,
    parameter logic [CPU_AW-1:0] IO_BASE     = 16'hFFF0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Req,
    input  logic                       We,
    input  logic [1:0]                 Be,
    input  logic [CPU_AW-1:0]          Addr,
    input  logic [DATA_W-1:0]          Wdata,
    output logic [DATA_W-1:0]          Rdata,
    output logic                       Ack,
    output logic                       Busy,
    input  logic [DATA_W-1:0]          Switches,
    output logic [NUM_DISP*DATA_W-1:0] Disp,
    output logic                       CE_n,
    output logic                       OE_n,
    output logic                       WE_n,
    output logic                       UB_n,
    output logic                       LB_n,
    output logic [SRAM_AW-1:0]         SRAM_ADDR,
    output logic [DATA_W-1:0]          Data_to_SRAM,
    output logic                       Data_oe,
    input  logic [DATA_W-1:0]          Data_from_SRAM
);

    // Lower byte lane width; the upper lane takes the remaining bits.
    localparam int         c_LO   = DATA_W / 2;
    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                     r_state;
    logic [3:0]                 r_cnt;
    logic                       r_we;
    logic [DATA_W-1:0]          r_rdata;
    logic                       r_ack;
    logic                       r_busy;
    logic                       r_ce_n;
    logic                       r_oe_n;
    logic                       r_we_n;
    logic                       r_ub_n;
    logic                       r_lb_n;
    logic [SRAM_AW-1:0]         r_sram_addr;
    logic [DATA_W-1:0]          r_wdata;
    logic                       r_data_oe;
    logic [NUM_DISP*DATA_W-1:0] r_disp;

    logic [CPU_AW-1:0]          w_off;
    logic                       w_io_hit;
    logic [DATA_W-1:0]          w_io_rdata;

    assign w_off    = Addr - IO_BASE;
    assign w_io_hit = (Addr >= IO_BASE) && (w_off < CPU_AW'(NUM_DISP));

    // I/O read mux: offset 0 returns the switches, higher offsets the display regs.
    always_comb begin
        w_io_rdata = Switches;
        for (int k = 1; k < NUM_DISP; k++) begin
            if (w_off == CPU_AW'(k)) begin
                w_io_rdata = r_disp[k*DATA_W +: DATA_W];
            end
        end
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_rdata     <= '0;
            r_ack       <= 1'b0;
            r_busy      <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_sram_addr <= '0;
            r_wdata     <= '0;
            r_data_oe   <= 1'b0;
            r_disp      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Req) begin
                        r_busy <= 1'b1;
                        if (w_io_hit) begin
                            // I/O window completes in one cycle and never reaches SRAM.
                            r_state <= S_DONE;
                            r_ack   <= 1'b1;
                            if (We) begin
                                for (int k = 0; k < NUM_DISP; k++) begin
                                    if (w_off == CPU_AW'(k)) begin
                                        if (Be[0]) r_disp[k*DATA_W +: c_LO] <= Wdata[c_LO-1:0];
                                        if (Be[1]) r_disp[k*DATA_W+c_LO +: DATA_W-c_LO] <= Wdata[DATA_W-1:c_LO];
                                    end
                                end
                            end else begin
                                r_rdata <= w_io_rdata;
                            end
                        end else begin
                            r_state     <= S_ACCESS;
                            r_cnt       <= '0;
                            r_we        <= We;
                            r_sram_addr <= SRAM_AW'(Addr);
                            r_ce_n      <= 1'b0;
                            r_ub_n      <= ~Be[1];
                            r_lb_n      <= ~Be[0];
                            r_oe_n      <= We;
                            r_we_n      <= ~We;
                            r_data_oe   <= We;
                            if (We) r_wdata <= Wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == c_WAIT) begin
                        // Final strobe edge: capture read data and release strobes.
                        r_state <= S_DONE;
                        r_ack   <= 1'b1;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_ub_n  <= 1'b1;
                        r_lb_n  <= 1'b1;
                        if (!r_we) r_rdata <= Data_from_SRAM;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    // Write data stays driven through DONE as a hold cycle.
                    r_state   <= S_IDLE;
                    r_ack     <= 1'b0;
                    r_busy    <= 1'b0;
                    r_data_oe <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Rdata        = r_rdata;
    assign Ack          = r_ack;
    assign Busy         = r_busy;
    assign CE_n         = r_ce_n;
    assign OE_n         = r_oe_n;
    assign WE_n         = r_we_n;
    assign UB_n         = r_ub_n;
    assign LB_n         = r_lb_n;
    assign SRAM_ADDR    = r_sram_addr;
    assign Data_to_SRAM = r_wdata;
    assign Data_oe      = r_data_oe;
    assign Disp         = r_disp;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_io_bridge
//  Brief    : Self-checking bench for mem_io_bridge (WAIT_CYCLES=2 and =0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_io_bridge;

    localparam int          NI  = 2;
    localparam logic [15:0] IOB = 16'hFFF0;
    localparam int          ND  = 2;

    logic        Clk = 1'b0, Reset = 1'b0, Req = 1'b0, We = 1'b0, mem_clr = 1'b0;
    logic [1:0]  Be = 2'b00;
    logic [15:0] Addr = '0, Wdata = '0, Switches = '0;

    logic [15:0] rdata [NI];
    logic        ack [NI], busy [NI], ce_n [NI], oe_n [NI], we_n [NI], ub_n [NI], lb_n [NI], doe [NI];
    logic [19:0] saddr [NI];
    logic [15:0] dts [NI], dfs [NI];
    logic [31:0] disp [NI];
    logic [15:0] sram [NI][256];

    int n_vec = 0, n_bad = 0;

    // Reference model: word-level memory, display registers, last read value.
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ref_disp [ND];
    logic [15:0] ref_rd;

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] sw;
        int          lat;
        logic [15:0] rd;
    } vec_t;
    vec_t tbl [15];

    mem_io_bridge #(.WAIT_CYCLES(2)) dut0 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .Be(Be), .Addr(Addr), .Wdata(Wdata),
        .Rdata(rdata[0]), .Ack(ack[0]), .Busy(busy[0]), .Switches(Switches), .Disp(disp[0]),
        .CE_n(ce_n[0]), .OE_n(oe_n[0]), .WE_n(we_n[0]), .UB_n(ub_n[0]), .LB_n(lb_n[0]),
        .SRAM_ADDR(saddr[0]), .Data_to_SRAM(dts[0]), .Data_oe(doe[0]), .Data_from_SRAM(dfs[0]));

    mem_io_bridge #(.WAIT_CYCLES(0)) dut1 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .Be(Be), .Addr(Addr), .Wdata(Wdata),
        .Rdata(rdata[1]), .Ack(ack[1]), .Busy(busy[1]), .Switches(Switches), .Disp(disp[1]),
        .CE_n(ce_n[1]), .OE_n(oe_n[1]), .WE_n(we_n[1]), .UB_n(ub_n[1]), .LB_n(lb_n[1]),
        .SRAM_ADDR(saddr[1]), .Data_to_SRAM(dts[1]), .Data_oe(doe[1]), .Data_from_SRAM(dfs[1]));

    always #5 Clk = ~Clk;

    // Asynchronous SRAM behaviour per instance (8 address bits are enough here).
    always @(posedge Clk) begin
        for (int i = 0; i < NI; i++) begin
            if (mem_clr) begin
                for (int j = 0; j < 256; j++) sram[i][j] <= 16'h0000;
            end else if (!ce_n[i] && !we_n[i]) begin
                if (!lb_n[i]) sram[i][saddr[i][7:0]][7:0]  <= dts[i][7:0];
                if (!ub_n[i]) sram[i][saddr[i][7:0]][15:8] <= dts[i][15:8];
            end
        end
    end

    assign dfs[0] = (!ce_n[0] && !oe_n[0]) ? sram[0][saddr[0][7:0]] : 16'hDEAD;
    assign dfs[1] = (!ce_n[1] && !oe_n[1]) ? sram[1][saddr[1][7:0]] : 16'hDEAD;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] memval(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    // One transaction on instance s; expectations from the table or the model.
    task automatic txn(input int s, input logic we_i, input logic [1:0] be_i,
                       input logic [15:0] a, input logic [15:0] wd, input logic [15:0] sw,
                       input int lat_i, input logic [15:0] rd_i, input bit use_model);
        int wc, k, exp_lat, ack_c, n_ack, n_ce, n_we, n_oe, n_doe, n_lane, n_inv, n_addr, n_busy;
        bit io;
        logic [15:0] exp_rd, old, merged;
        wc = (s == 0) ? 2 : 0;
        io = (int'(a) >= int'(IOB)) && (int'(a) < int'(IOB) + ND);
        k  = int'(a) - int'(IOB);
        old = (io && k >= 0 && k < ND) ? ref_disp[k] : memval(a);
        merged = {be_i[1] ? wd[15:8] : old[15:8], be_i[0] ? wd[7:0] : old[7:0]};
        exp_lat = io ? 1 : wc + 2;
        exp_rd  = we_i ? ref_rd : ((io && k == 0) ? sw : old);
        if (we_i) begin
            if (io) ref_disp[k] = merged;
            else    ref_mem[a]  = merged;
        end
        ref_rd = exp_rd;
        if (!use_model) begin
            exp_lat = lat_i;
            exp_rd  = rd_i;
        end

        @(negedge Clk);
        Req = 1'b1; We = we_i; Be = be_i; Addr = a; Wdata = wd; Switches = sw;
        @(posedge Clk);
        #1 Req = 1'b0;
        ack_c = -1; n_ack = 0; n_ce = 0; n_we = 0; n_oe = 0; n_doe = 0;
        n_lane = 0; n_inv = 0; n_addr = 0; n_busy = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge Clk);
            if (ack[s]) begin
                n_ack++;
                if (ack_c < 0) begin
                    ack_c = c;
                    chk("rdata", rdata[s], exp_rd);
                    chk("disp", disp[s], {ref_disp[1], ref_disp[0]});
                end
            end
            if (busy[s] !== (ack_c < 0 || c == ack_c)) n_busy++;
            if (!ce_n[s]) begin
                n_ce++;
                if (ub_n[s] !== ~be_i[1] || lb_n[s] !== ~be_i[0]) n_lane++;
                if (saddr[s] !== {4'h0, a}) n_addr++;
            end
            if (!we_n[s]) n_we++;
            if (!oe_n[s]) n_oe++;
            if (doe[s])   n_doe++;
            if ((doe[s] && !oe_n[s]) || (!we_n[s] && !oe_n[s])) n_inv++;
            if (ack_c > 0 && c >= ack_c + 1) break;
        end
        chk("ack_latency", ack_c, exp_lat);
        chk("ack_pulses", n_ack, 1);
        chk("strobe_cycles", {8'(n_ce), 8'(n_we), 8'(n_oe), 8'(n_doe)},
            {8'(io ? 0 : wc + 1), 8'((!io && we_i) ? wc + 1 : 0),
             8'((!io && !we_i) ? wc + 1 : 0), 8'((!io && we_i) ? wc + 2 : 0)});
        chk("protocol_errs", {8'(n_lane), 8'(n_inv), 8'(n_addr), 8'(n_busy)}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, second, cnt, r;
        logic [15:0] a;

        tbl[0]  = '{1'b1, 2'b11, 16'h0010, 16'h1234, 16'h0000, 4, 16'h0000};
        tbl[1]  = '{1'b0, 2'b11, 16'h0010, 16'h0000, 16'h0000, 4, 16'h1234};
        tbl[2]  = '{1'b0, 2'b11, 16'hFFF0, 16'h0000, 16'hBEEF, 1, 16'hBEEF};
        tbl[3]  = '{1'b1, 2'b01, 16'hFFF1, 16'hA5A5, 16'h0000, 1, 16'hBEEF};
        tbl[4]  = '{1'b0, 2'b11, 16'hFFF1, 16'h0000, 16'h0000, 1, 16'h00A5};
        tbl[5]  = '{1'b1, 2'b10, 16'h0010, 16'hFFEE, 16'h0000, 4, 16'h00A5};
        tbl[6]  = '{1'b0, 2'b01, 16'h0010, 16'h0000, 16'h0000, 4, 16'hFF34};
        tbl[7]  = '{1'b1, 2'b00, 16'h0020, 16'h9999, 16'h0000, 4, 16'hFF34};
        tbl[8]  = '{1'b0, 2'b11, 16'h0020, 16'h0000, 16'h0000, 4, 16'h0000};
        tbl[9]  = '{1'b1, 2'b11, 16'hFFF0, 16'h1357, 16'h0000, 1, 16'h0000};
        tbl[10] = '{1'b0, 2'b11, 16'hFFF0, 16'h0000, 16'h2468, 1, 16'h2468};
        tbl[11] = '{1'b0, 2'b11, 16'hFFF2, 16'h0000, 16'h0000, 4, 16'h0000};
        tbl[12] = '{1'b0, 2'b11, 16'hFFEF, 16'h0000, 16'h0000, 4, 16'h0000};
        tbl[13] = '{1'b1, 2'b00, 16'hFFF1, 16'h1111, 16'h0000, 1, 16'h0000};
        tbl[14] = '{1'b0, 2'b11, 16'hFFF1, 16'h0000, 16'h0000, 1, 16'h00A5};

        for (int i = 0; i < ND; i++) ref_disp[i] = 16'h0000;
        ref_rd = 16'h0000;

        mem_clr = 1'b1;
        repeat (3) @(posedge Clk);
        #1 mem_clr = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("reset_strobes", {ce_n[0], oe_n[0], we_n[0], ub_n[0], lb_n[0]}, 5'h1F);
        chk("reset_ctl", {ack[0], busy[0], doe[0]}, 3'b000);
        chk("reset_data", {rdata[0], dts[0], saddr[0]}, 52'h0);
        chk("reset_disp", disp[0], 32'h0);

        for (int i = 0; i < 15; i++)
            txn(0, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wd, tbl[i].sw, tbl[i].lat, tbl[i].rd, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 11));
            a = (r < 6) ? 16'(r) : 16'(int'(16'hFFEE) + r - 6);
            txn(0, 1'($urandom), 2'($urandom), a, 16'($urandom), 16'($urandom), 0, 16'h0, 1'b1);
        end

        // Req held high across two reads: one idle cycle between DONE and the next accept.
        @(negedge Clk);
        Req = 1'b1; We = 1'b0; Be = 2'b11; Addr = 16'h0010;
        first = -1; second = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (ack[0]) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (second > 0) break;
        end
        Req = 1'b0;
        ref_rd = memval(16'h0010);
        chk("b2b_ack_spacing", second - first, 5);
        chk("b2b_rdata", rdata[0], ref_rd);
        @(negedge Clk);

        // A request pulse during an SRAM access is dropped.
        @(negedge Clk);
        Req = 1'b1; We = 1'b0; Be = 2'b11; Addr = 16'h0011; Switches = 16'h7777;
        @(posedge Clk);
        #1 Req = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Req = 1'b1; Addr = IOB;
        cnt = 0;
        @(negedge Clk);
        Req = 1'b0;
        if (ack[0]) cnt++;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            if (ack[0]) cnt++;
        end
        ref_rd = memval(16'h0011);
        chk("busy_req_dropped", cnt, 1);
        chk("busy_rdata", rdata[0], ref_rd);

        // Asynchronous reset in the middle of an SRAM write.
        @(negedge Clk);
        Req = 1'b1; We = 1'b1; Be = 2'b11; Addr = 16'h0030; Wdata = 16'hCAFE;
        @(posedge Clk);
        #1 Req = 1'b0;
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        chk("midrst_strobes", {ce_n[0], oe_n[0], we_n[0], ub_n[0], lb_n[0]}, 5'h1F);
        chk("midrst_ctl", {ack[0], busy[0], doe[0]}, 3'b000);
        chk("midrst_disp", disp[0], 32'h0);
        chk("midrst_data", {rdata[0], saddr[0]}, 36'h0);
        @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < ND; i++) ref_disp[i] = 16'h0000;
        ref_rd = 16'h0000;
        @(negedge Clk);

        // Zero wait states: single ACCESS cycle, upper-lane write, then read-back.
        txn(1, 1'b1, 2'b10, 16'h0005, 16'hAB00, 16'h0000, 0, 16'h0, 1'b1);
        txn(1, 1'b0, 2'b11, 16'h0005, 16'h0000, 16'h0000, 0, 16'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
